apb_req_arbiter: RTL and testbench

//  Two-requester APB master/arbiter that shares one APB completer (apb_slave memory) between requesters A and B.

---
 rtl/apb_req_arbiter.sv | 136 +++++++++++++
 tb/tb_apb_req_arbiter.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/apb_req_arbiter.sv
// apb_req_arbiter: round-robin two-requester APB master with pready watchdog
module apb_req_arbiter #(
    parameter int addrWidth = 32,
    parameter int dataWidth = 32,
    parameter int TIMEOUT   = 16
) (
    input  logic                 pclk,
    input  logic                 rst_n,
    input  logic                 a_valid,
    output logic                 a_ready,
    input  logic                 a_write,
    input  logic [addrWidth-1:0] a_addr,
    input  logic [dataWidth-1:0] a_wdata,
    input  logic                 b_valid,
    output logic                 b_ready,
    input  logic                 b_write,
    input  logic [addrWidth-1:0] b_addr,
    input  logic [dataWidth-1:0] b_wdata,
    output logic                 rsp_done,
    output logic                 rsp_id,
    output logic [dataWidth-1:0] rsp_rdata,
    output logic                 rsp_err,
    output logic [addrWidth-1:0] paddr,
    output logic                 pwrite,
    output logic                 psel,
    output logic                 penable,
    output logic [dataWidth-1:0] pwdata,
    input  logic [dataWidth-1:0] prdata,
    input  logic                 pready
);
    localparam int WW = $clog2(TIMEOUT) + 1;

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

    state_t               state, state_n;
    logic                 owner, owner_n, last_grant, last_grant_n;
    logic [WW-1:0]        wdog, wdog_n;
    logic                 a_ready_n, b_ready_n, rsp_done_n, rsp_id_n, rsp_err_n;
    logic                 pwrite_n, psel_n, penable_n, pick;
    logic [dataWidth-1:0] rsp_rdata_n, pwdata_n;
    logic [addrWidth-1:0] paddr_n;

    // B wins when it is the only requester or when A was served last
    assign pick = b_valid & (~a_valid | ~last_grant);

    // next-state and next-output values; every output is registered below
    always_comb begin
        state_n      = state;
        owner_n      = owner;
        last_grant_n = last_grant;
        wdog_n       = wdog;
        a_ready_n    = 1'b0;
        b_ready_n    = 1'b0;
        rsp_done_n   = 1'b0;
        rsp_id_n     = rsp_id;
        rsp_err_n    = rsp_err;
        rsp_rdata_n  = rsp_rdata;
        paddr_n      = paddr;
        pwrite_n     = pwrite;
        pwdata_n     = pwdata;
        psel_n       = psel;
        penable_n    = penable;
        case (state)
            IDLE: begin
                if (a_valid | b_valid) begin
                    owner_n   = pick;
                    paddr_n   = pick ? b_addr : a_addr;
                    pwrite_n  = pick ? b_write : a_write;
                    pwdata_n  = pick ? b_wdata : a_wdata;
                    a_ready_n = ~pick;
                    b_ready_n = pick;
                    psel_n    = 1'b1;
                    penable_n = 1'b0;
                    state_n   = SETUP;
                end
            end
            SETUP: begin
                penable_n = 1'b1;
                wdog_n    = '0;
                state_n   = ACCESS;
            end
            ACCESS: begin
                if (pready || wdog == WW'(TIMEOUT - 1)) begin
                    psel_n       = 1'b0;
                    penable_n    = 1'b0;
                    rsp_done_n   = 1'b1;
                    rsp_id_n     = owner;
                    rsp_err_n    = ~pready;
                    rsp_rdata_n  = (pready && !pwrite) ? prdata : rsp_rdata;
                    last_grant_n = owner;
                    state_n      = IDLE;
                end else begin
                    wdog_n = wdog + 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // state and output registers; reset aborts any transfer in flight
    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            owner      <= 1'b0;
            last_grant <= 1'b1;
            wdog       <= '0;
            a_ready    <= 1'b0;
            b_ready    <= 1'b0;
            rsp_done   <= 1'b0;
            rsp_id     <= 1'b0;
            rsp_err    <= 1'b0;
            rsp_rdata  <= '0;
            paddr      <= '0;
            pwrite     <= 1'b0;
            pwdata     <= '0;
            psel       <= 1'b0;
            penable    <= 1'b0;
        end else begin
            state      <= state_n;
            owner      <= owner_n;
            last_grant <= last_grant_n;
            wdog       <= wdog_n;
            a_ready    <= a_ready_n;
            b_ready    <= b_ready_n;
            rsp_done   <= rsp_done_n;
            rsp_id     <= rsp_id_n;
            rsp_err    <= rsp_err_n;
            rsp_rdata  <= rsp_rdata_n;
            paddr      <= paddr_n;
            pwrite     <= pwrite_n;
            pwdata     <= pwdata_n;
            psel       <= psel_n;
            penable    <= penable_n;
        end
    end
endmodule

// File: tb/tb_apb_req_arbiter.sv
// tb_apb_req_arbiter: directed bench with a memory APB completer model
module tb_apb_req_arbiter;
    logic        pclk = 1'b0, rst_n = 1'b0;
    logic        a_valid = 1'b0, a_write = 1'b0, b_valid = 1'b0, b_write = 1'b0;
    logic [31:0] a_addr = '0, a_wdata = '0, b_addr = '0, b_wdata = '0;
    logic        a_ready, b_ready, rsp_done, rsp_id, rsp_err;
    logic [31:0] rsp_rdata, paddr, pwdata, prdata;
    logic        pwrite, psel, penable, pready;
    logic        seen, stall = 1'b0, a_pend = 1'b0, b_pend = 1'b0;
    logic [31:0] mem [256] = '{default: 32'h0};
    int          cmp = 0, errs = 0, n;

    apb_req_arbiter #(.addrWidth(32), .dataWidth(32), .TIMEOUT(16)) dut (
        .pclk(pclk), .rst_n(rst_n),
        .a_valid(a_valid), .a_ready(a_ready), .a_write(a_write), .a_addr(a_addr), .a_wdata(a_wdata),
        .b_valid(b_valid), .b_ready(b_ready), .b_write(b_write), .b_addr(b_addr), .b_wdata(b_wdata),
        .rsp_done(rsp_done), .rsp_id(rsp_id), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .paddr(paddr), .pwrite(pwrite), .psel(psel), .penable(penable), .pwdata(pwdata),
        .prdata(prdata), .pready(pready)
    );

    always #5 pclk = ~pclk;

    // completer: pready in the second ACCESS cycle unless stalled
    assign pready = psel & penable & seen & ~stall;
    assign prdata = mem[paddr[7:0]];

    always @(posedge pclk or negedge rst_n)
        if (!rst_n) seen <= 1'b0;
        else seen <= psel & penable & ~pready;

    always @(posedge pclk)
        if (pready && pwrite) mem[paddr[7:0]] <= pwdata;

    // requesters must hold valid until their ready pulse
    always @(posedge pclk) begin
        if (rst_n && ((a_pend && !a_valid && !a_ready) || (b_pend && !b_valid && !b_ready))) begin
            errs++;
            $error("FAIL valid_hold: valid dropped before ready");
        end
        a_pend <= a_valid & ~a_ready;
        b_pend <= b_valid & ~b_ready;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        cmp++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic req(input bit id, input bit wr, input logic [31:0] addr, input logic [31:0] wd);
        if (id) begin
            b_valid = 1'b1; b_write = wr; b_addr = addr; b_wdata = wd;
        end else begin
            a_valid = 1'b1; a_write = wr; a_addr = addr; a_wdata = wd;
        end
    endtask

    task automatic drop(input bit id);
        if (id) b_valid = 1'b0;
        else a_valid = 1'b0;
    endtask

    task automatic wait_for(input int w, input logic [31:0] addr, input logic [31:0] wd,
                            input bit bus, output int cnt);
        logic s;
        cnt = 0;
        do begin
            @(negedge pclk);
            cnt++;
            if (bus && psel && penable) begin
                chk("paddr_stable", paddr, addr);
                chk("pwdata_stable", pwdata, wd);
            end
            s = (w == 0) ? a_ready : (w == 1) ? b_ready : rsp_done;
        end while (!s && cnt < 100);
        chk("wait_bound", 32'(cnt < 100), 32'd1);
    endtask

    task automatic xfer(input bit id, input bit wr, input logic [31:0] addr, input logic [31:0] wd,
                        input logic [31:0] erd, input bit eerr, input int elat);
        int c;
        req(id, wr, addr, wd);
        wait_for(id ? 1 : 0, addr, wd, 1'b0, c);
        chk("grant_lat", 32'(c), 32'd1);
        chk("setup_phase", 32'({psel, penable}), 32'd2);
        chk("pwrite", 32'(pwrite), 32'(wr));
        chk("other_ready", 32'(id ? a_ready : b_ready), 32'd0);
        drop(id);
        wait_for(2, addr, wd, 1'b1, c);
        chk("done_lat", 32'(c), 32'(elat));
        chk("rsp_id", 32'(rsp_id), 32'(id));
        chk("rsp_err", 32'(rsp_err), 32'(eerr));
        chk("rsp_rdata", rsp_rdata, erd);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        repeat (2) @(negedge pclk);
        chk("rst_psel", 32'(psel), 32'd0);
        chk("rst_penable", 32'(penable), 32'd0);
        chk("rst_ready", 32'({a_ready, b_ready}), 32'd0);
        chk("rst_done", 32'({rsp_done, rsp_err, rsp_id}), 32'd0);
        chk("rst_rdata", rsp_rdata, 32'h0);
        chk("rst_paddr", paddr, 32'h0);
        rst_n = 1'b1;
        @(negedge pclk);
        chk("idle_psel", 32'(psel), 32'd0);

        req(1'b0, 1'b1, 32'h01, 32'h11);
        req(1'b1, 1'b1, 32'h02, 32'h22);
        wait_for(0, 0, 0, 1'b0, n);
        chk("cont_a_lat", 32'(n), 32'd1);
        chk("cont_b_wait", 32'(b_ready), 32'd0);
        drop(1'b0);
        wait_for(2, 32'h01, 32'h11, 1'b1, n);
        chk("cont_a_done", 32'(n), 32'd3);
        chk("cont_id0", 32'(rsp_id), 32'd0);
        wait_for(1, 0, 0, 1'b0, n);
        chk("cont_b_lat", 32'(n), 32'd1);
        drop(1'b1);
        req(1'b0, 1'b1, 32'h01, 32'h33);
        wait_for(2, 32'h02, 32'h22, 1'b1, n);
        chk("cont_b_done", 32'(n), 32'd3);
        chk("cont_id1", 32'(rsp_id), 32'd1);
        req(1'b1, 1'b1, 32'h03, 32'h44);
        wait_for(0, 0, 0, 1'b0, n);
        chk("rr_a_lat", 32'(n), 32'd1);
        chk("rr_b_wait", 32'(b_ready), 32'd0);
        drop(1'b0);
        wait_for(2, 32'h01, 32'h33, 1'b1, n);
        chk("rr_id0", 32'(rsp_id), 32'd0);
        wait_for(1, 0, 0, 1'b0, n);
        drop(1'b1);
        wait_for(2, 32'h03, 32'h44, 1'b1, n);
        chk("rr_id1", 32'(rsp_id), 32'd1);
        chk("rr_rdata", rsp_rdata, 32'h0);

        xfer(1'b0, 1'b0, 32'h20, 32'h0, 32'h0, 1'b0, 3);
        xfer(1'b0, 1'b1, 32'h10, 32'hCAFE_F00D, 32'h0, 1'b0, 3);
        xfer(1'b0, 1'b0, 32'h10, 32'h0, 32'hCAFE_F00D, 1'b0, 3);
        xfer(1'b0, 1'b0, 32'h01, 32'h0, 32'h33, 1'b0, 3);
        xfer(1'b1, 1'b0, 32'h02, 32'h0, 32'h22, 1'b0, 3);
        xfer(1'b0, 1'b0, 32'h03, 32'h0, 32'h44, 1'b0, 3);

        stall = 1'b1;
        xfer(1'b0, 1'b0, 32'h30, 32'h0, 32'h44, 1'b1, 17);
        stall = 1'b0;
        @(negedge pclk);
        chk("done_pulse", 32'(rsp_done), 32'd0);
        chk("abort_psel", 32'(psel), 32'd0);
        xfer(1'b0, 1'b0, 32'h10, 32'h0, 32'hCAFE_F00D, 1'b0, 3);

        req(1'b1, 1'b0, 32'h10, 32'h0);
        wait_for(1, 0, 0, 1'b0, n);
        drop(1'b1);
        @(negedge pclk);
        chk("pre_rst_access", 32'({psel, penable}), 32'd3);
        #2 rst_n = 1'b0;
        #1;
        chk("async_psel", 32'({psel, penable}), 32'd0);
        chk("async_done", 32'(rsp_done), 32'd0);
        chk("async_rdata", rsp_rdata, 32'h0);
        @(negedge pclk);
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge pclk);
            chk("no_done_after_rst", 32'({rsp_done, psel}), 32'd0);
        end
        xfer(1'b0, 1'b0, 32'h02, 32'h0, 32'h22, 1'b0, 3);

        for (int i = 0; i < 8; i++)
            xfer(1'b1, 1'b1, 32'h40 + 32'(i), 32'h1111 * 32'(i), 32'h22, 1'b0, 3);
        xfer(1'b1, 1'b0, 32'h47, 32'h0, 32'h7777, 1'b0, 3);
        xfer(1'b0, 1'b0, 32'h43, 32'h0, 32'h3333, 1'b0, 3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, errs);
        $finish;
    end
endmodule
